// File: rtl/foo_pkg.sv
// Shared constants and types for the foo lane packer.
//   LANE_W     : default per-lane result width
//   DROP_CNT_W : width of the saturating drop counter
//   beat_t     : one packed two-lane beat at the default lane width
package foo_pkg;

  localparam int unsigned LANE_W     = 64;
  localparam int unsigned DROP_CNT_W = 16;

  typedef logic [2*LANE_W-1:0] beat_t;

endpackage

// File: rtl/foo_sync_fifo.sv
// Generic count-based synchronous FIFO. Full and empty are decided by the
// occupancy counter only, never by comparing pointers.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset (pointers and count cleared)
//   push  : write wdata at the write pointer (caller guarantees not full, or
//           a simultaneous pop)
//   pop   : advance the read pointer (caller guarantees not empty)
//   wdata : write data
//   rdata : head entry, driven combinationally from storage
//   count : current occupancy, 0..Depth
module foo_sync_fifo #(
  parameter int unsigned Width = 128,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic [CntW-1:0]  count
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Depth is a power of two, so the pointers wrap by plain overflow.
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/foo_lane_packer.sv
// Packs the two 64-bit lane results of the foo array into one beat {x1, x0},
// buffers beats in a small FIFO and presents them on a valid/ready stream.
// The producer cannot be stalled: a beat arriving while the FIFO is full
// (and not being drained that cycle) is dropped and counted.
// Optional feature macro: FOO_PACKER_CHECKSUM_EN adds a running XOR of all
// popped beats on the checksum port.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   in_valid   : lanes carry a result this cycle
//   x0, x1     : lane 0 / lane 1 results
//   out_valid  : head beat available
//   out_ready  : consumer accepts head beat
//   out_data   : head beat {x1, x0}
//   count      : FIFO occupancy
//   overflow   : sticky, a beat has been dropped since reset
//   drop_cnt   : saturating count of dropped beats
//   checksum   : XOR of popped beats (only with FOO_PACKER_CHECKSUM_EN)
module foo_lane_packer
  import foo_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = LANE_W,
  localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      x0,
  input  logic [WIDTH-1:0]      x1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*WIDTH-1:0]    out_data,
  output logic [CntW-1:0]       count,
  output logic                  overflow,
`ifdef FOO_PACKER_CHECKSUM_EN
  output logic [2*WIDTH-1:0]    checksum,
`endif
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  drop;
  logic [CntW-1:0]       fifo_count;
  logic [2*WIDTH-1:0]    fifo_rdata;

  logic                  overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // out_valid depends on registered occupancy only, so out_ready never
  // reaches out_valid or out_data combinationally.
  assign out_valid = (fifo_count != '0);
  assign full      = (fifo_count == FullCnt);
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push      = in_valid && (!full || pop);
  assign drop      = in_valid && full && !pop;

  foo_sync_fifo #(
    .Width (2*WIDTH),
    .Depth (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({x1, x0}),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

`ifdef FOO_PACKER_CHECKSUM_EN
  logic [2*WIDTH-1:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (pop) begin
      checksum_d = checksum_q ^ fifo_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

  assign out_data = fifo_rdata;
  assign count    = fifo_count;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule
